// File: rtl/word_serializer_pkg.sv
// Shared types and constants for the word serializer slice.
// Defaults, the FSM state encoding and the even-parity helper.
package word_serializer_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 6;
  // The parity helper takes a fixed-size vector; words up to 64 bits are zero-extended into it.
  localparam int PAR_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  // Even parity over a zero-padded word; padding bits do not change the XOR.
  function automatic logic even_parity(input logic [0:PAR_MAX_W-1] word);
    return ^word;
  endfunction

endpackage

// File: rtl/word_serializer_if.sv
// Parallel-load handshake and serial link signals of the word serializer.
// The master side loads words and observes the link; the slave side is the serializer.
interface word_serializer_if
  import word_serializer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic [0:WIDTH-1] din;
  logic             load_valid;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             frame;
  logic             done;

  modport master (
    output din, load_valid,
    input  load_ready, sout, sout_valid, frame, done
  );

  modport slave (
    input  din, load_valid,
    output load_ready, sout, sout_valid, frame, done
  );

endinterface

// File: rtl/word_serializer_bit_counter.sv
// Bit-position counter for the serializer: clear on load, count while shifting,
// saturate at the last index. Flags the last and second-to-last positions.
module ser_bit_counter
  import word_serializer_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int LAST  = DEF_WIDTH - 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic at_last,
  output logic near_last
);

  logic [CNT_W-1:0] count_q, count_d;

  assign at_last   = (count_q == CNT_W'(LAST));
  assign near_last = (count_q == CNT_W'(LAST - 1));

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !at_last) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial word unloader, element [0] first, with frame/valid/done framing.
// Optional even-parity trailer bit when SERIALIZER_PARITY_EN is defined.
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  word_serializer_if.slave bus
);

  state_e           state_q, state_d;
  logic [0:WIDTH-1] word_q, word_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             frame_q, frame_d;
  logic             done_q, done_d;
  logic             cnt_clr, cnt_en;
  logic             at_last, near_last;

`ifdef SERIALIZER_PARITY_EN
  logic                 parity_q, parity_d;
  logic [0:PAR_MAX_W-1] par_ext;
`endif

  ser_bit_counter #(
    .CNT_W (CNT_W),
    .LAST  (WIDTH - 1)
  ) u_bit_counter (
    .clk       (clk),
    .rst_n     (reset),
    .clr       (cnt_clr),
    .en        (cnt_en),
    .at_last   (at_last),
    .near_last (near_last)
  );

  assign bus.load_ready = (state_q == IDLE);
  assign bus.sout       = sout_q;
  assign bus.sout_valid = sout_valid_q;
  assign bus.frame      = frame_q;
  assign bus.done       = done_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    sout_d       = 1'b0;
    sout_valid_d = 1'b0;
    frame_d      = 1'b0;
    done_d       = 1'b0;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    parity_d              = parity_q;
    par_ext               = '0;
    par_ext[0:WIDTH-1]    = bus.din;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.load_valid) begin
          state_d      = SHIFT;
          word_d       = bus.din;
          sout_d       = bus.din[0];
          sout_valid_d = 1'b1;
          frame_d      = 1'b1;
          cnt_clr      = 1'b1;
`ifdef SERIALIZER_PARITY_EN
          parity_d     = even_parity(par_ext);
`endif
        end
      end

      SHIFT: begin
        if (at_last) begin
`ifdef SERIALIZER_PARITY_EN
          state_d      = PARITY;
          sout_d       = parity_q;
          sout_valid_d = 1'b1;
          done_d       = 1'b1;
`else
          state_d      = IDLE;
`endif
        end else begin
          // The word shifts toward index 0, so word_q[1] is always the next bit out.
          cnt_en       = 1'b1;
          word_d       = {word_q[1:WIDTH-1], 1'b0};
          sout_d       = word_q[1];
          sout_valid_d = 1'b1;
`ifndef SERIALIZER_PARITY_EN
          done_d       = near_last;
`endif
        end
      end

      PARITY: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: the captured word is an ordinary register, not a memory, so it is cleared on reset too.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      word_q       <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      frame_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      frame_q      <= frame_d;
      done_q       <= done_d;
    end
  end

`ifdef SERIALIZER_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: 32-bit and 8-bit instances on one clock and reset.
// Covers idle reset state, framing, back-to-back loads, mid-frame reset and the parity option.
module tb_word_serializer;

`ifdef SERIALIZER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  word_serializer_if #(.WIDTH(32)) bus32 ();
  word_serializer_if #(.WIDTH(8))  bus8 ();

  word_serializer #(.WIDTH(32), .CNT_W(6)) dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus32.slave)
  );

  word_serializer #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle32(input string tag);
    check({tag, " sout"},       32'(bus32.sout),       32'd0);
    check({tag, " sout_valid"}, 32'(bus32.sout_valid), 32'd0);
    check({tag, " frame"},      32'(bus32.frame),      32'd0);
    check({tag, " done"},       32'(bus32.done),       32'd0);
    check({tag, " load_ready"}, 32'(bus32.load_ready), 32'd1);
  endtask

  // Called at the negedge where bit 0 is visible; returns at the negedge after the last bit.
  task automatic check_bits32(input logic [0:31] w, input string tag);
    logic exp_bit;
    for (int i = 0; i < 32 + PAR; i++) begin
      if (i < 32) exp_bit = w[i];
      else        exp_bit = ^w;
      check($sformatf("%s bit%0d sout", tag, i),  32'(bus32.sout),       32'(exp_bit));
      check($sformatf("%s bit%0d valid", tag, i), 32'(bus32.sout_valid), 32'd1);
      check($sformatf("%s bit%0d frame", tag, i), 32'(bus32.frame),      32'(i == 0));
      check($sformatf("%s bit%0d done", tag, i),  32'(bus32.done),       32'(i == 31 + PAR));
      check($sformatf("%s bit%0d ready", tag, i), 32'(bus32.load_ready), 32'd0);
      @(negedge clk);
    end
  endtask

  task automatic check_bits8(input logic [0:7] w, input string tag);
    logic exp_bit;
    for (int i = 0; i < 8 + PAR; i++) begin
      if (i < 8) exp_bit = w[i];
      else       exp_bit = ^w;
      check($sformatf("%s bit%0d sout", tag, i),  32'(bus8.sout),       32'(exp_bit));
      check($sformatf("%s bit%0d valid", tag, i), 32'(bus8.sout_valid), 32'd1);
      check($sformatf("%s bit%0d frame", tag, i), 32'(bus8.frame),      32'(i == 0));
      check($sformatf("%s bit%0d done", tag, i),  32'(bus8.done),       32'(i == 7 + PAR));
      @(negedge clk);
    end
  endtask

  // Offer one word, drop valid and scramble din after acceptance, then check the frame and the gap.
  task automatic run_frame32(input logic [0:31] w, input string tag);
    @(negedge clk);
    check({tag, " ready before load"}, 32'(bus32.load_ready), 32'd1);
    bus32.din        = w;
    bus32.load_valid = 1'b1;
    @(negedge clk);
    bus32.load_valid = 1'b0;
    bus32.din        = ~w;
    check_bits32(w, tag);
    check_idle32({tag, " after"});
  endtask

  initial begin
    logic [0:31] wa;
    logic [0:31] wb;
    logic [0:7]  w8;

    reset            = 1'b0;
    bus32.din        = '0;
    bus32.load_valid = 1'b0;
    bus8.din         = '0;
    bus8.load_valid  = 1'b0;

    // 1: reset state, then a second reset pulse in the middle of idle.
    repeat (2) @(negedge clk);
    check_idle32("in reset");
    reset = 1'b1;
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_idle32("idle reset");
    check("idle8 valid", 32'(bus8.sout_valid), 32'd0);
    check("idle8 ready", 32'(bus8.load_ready), 32'd1);

    // 2 / 3: end bits set; then low bits set, which also exercises parity when compiled in.
    run_frame32(32'h8000_0001, "w80000001");
    run_frame32(32'h0000_0007, "w00000007");

    // 4: valid held high across two words; B must wait out A and then one idle cycle.
    wa = 32'hC3A5_0F96;
    wb = 32'h1234_5678;
    @(negedge clk);
    bus32.din        = wa;
    bus32.load_valid = 1'b1;
    @(negedge clk);
    bus32.din = wb;
    check_bits32(wa, "b2b A");
    check("b2b gap valid", 32'(bus32.sout_valid), 32'd0);
    check("b2b gap ready", 32'(bus32.load_ready), 32'd1);
    @(negedge clk);
    bus32.load_valid = 1'b0;
    check_bits32(wb, "b2b B");
    check_idle32("b2b after");

    // 5: asynchronous reset while bit 10 is on the line, between clock edges.
    wa = 32'h0020_0000;
    @(negedge clk);
    bus32.din        = wa;
    bus32.load_valid = 1'b1;
    @(negedge clk);
    bus32.load_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst bit10 sout",  32'(bus32.sout),       32'd1);
    check("midrst bit10 valid", 32'(bus32.sout_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_idle32("midrst async");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("midrst held%0d done", i),  32'(bus32.done),       32'd0);
      check($sformatf("midrst held%0d valid", i), 32'(bus32.sout_valid), 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    check_idle32("midrst release");
    check("midrst no resume", 32'(bus32.done), 32'd0);
    run_frame32(32'hF0F0_1234, "postrst");

    // 6: narrow instance.
    w8 = 8'hA5;
    @(negedge clk);
    check("w8 ready", 32'(bus8.load_ready), 32'd1);
    bus8.din        = w8;
    bus8.load_valid = 1'b1;
    @(negedge clk);
    bus8.load_valid = 1'b0;
    bus8.din        = 8'h00;
    check_bits8(w8, "wA5");
    check("wA5 after valid", 32'(bus8.sout_valid), 32'd0);
    check("wA5 after ready", 32'(bus8.load_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
